muldiv: RTL and testbench

Multi-cycle integer multiply/divide unit in the execute stage, alongside the ALU and fed the same `a`/`b` operands. It performs MULT, MULTU, DIV and DIVU iteratively, one bit per clock, and holds the 64-bit result in internal HI/LO registers for later `mfhi`/`mflo` reads. The pipeline stalls on `busy`; single-cycle ALU operations are unaffected.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv.sv | 141 ++++++++++++++
 tb/tb_muldiv.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and constants for the iterative mul/div unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    // Number of one-bit iterations per operation
    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } muldiv_state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration: shift-add multiply or
//                restoring shift-subtract divide on the double-width acc.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] trial;
    logic             unused_trial_msb;

    // Remainder is below the divisor, so after a successful subtract bit WIDTH is zero
    assign unused_trial_msb = trial[WIDTH];

    // Select the multiply or divide iteration
    always_comb begin
        // Multiply: conditional add into upper half with carry, then shift right
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Divide: upper half after a left shift is acc[2W-1:W-1] (WIDTH+1 bits)
        trial   = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, operand};
        if (is_div) begin
            if (!trial[WIDTH+1]) begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv.sv
// ============================================================================
//  Module      : muldiv
//  Description : Iterative signed/unsigned multiply and divide unit with
//                HI/LO result registers (one bit per clock).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    muldiv_state_t      state;
    muldiv_op_t         op_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      count;
    logic               sa;
    logic               sb;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               is_div;
    logic               div_zero;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Operand signs only matter for the signed ops (op[0]==0)
    assign sign_a = ~op[0] & a[WIDTH-1];
    assign sign_b = ~op[0] & b[WIDTH-1];
    assign abs_a  = sign_a ? -a : a;
    assign abs_b  = sign_b ? -b : b;

    assign is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    // For divides opnd holds |b|, so a zero divisor is visible there
    assign div_zero = is_div && (opnd == '0);
    assign busy     = (state != ST_IDLE);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .operand  (opnd),
        .is_div   (is_div),
        .acc_next (acc_next)
    );

    // Sign correction of the magnitude result; divide-by-zero overrides LO
    always_comb begin
        prod   = (sa ^ sb) ? -acc : acc;
        quo    = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            // With b==0 the remainder is |a| and sb is 0, so rem is the original a
            fix_hi = rem;
            fix_lo = div_zero ? '1 : quo;
        end
    end

    // Control FSM, iteration datapath and HI/LO result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= OP_MULT;
            acc   <= '0;
            opnd  <= '0;
            count <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= muldiv_op_t'(op);
                        sa    <= sign_a;
                        sb    <= sign_b;
                        count <= '0;
                        state <= ST_CALC;
                        if (op[1]) begin
                            opnd <= abs_b;
                            acc  <= {{WIDTH{1'b0}}, abs_a};
                        end else begin
                            opnd <= abs_a;
                            acc  <= {{WIDTH{1'b0}}, abs_b};
                        end
                    end
                end
                ST_CALC: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    dz    <= div_zero;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv.sv
// ============================================================================
//  Module      : tb_muldiv
//  Description : Scoreboard testbench for the muldiv unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;

    muldiv #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (vec %0d): got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: compare every completed operation against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("hi",      mon_e.id, hi,                mon_e.hi);
                chk("lo",      mon_e.id, lo,                mon_e.lo);
                chk("dz",      mon_e.id, {31'd0, dz},       {31'd0, mon_e.dz});
                chk("latency", mon_e.id, 32'(cyc),          32'(mon_e.cyc));
            end
        end
    end

    // Issue one operation (caller sits just after a negedge) and log its expected result
    task automatic issue(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed, input int id);
        exp_t e;
        op    = o;
        a     = xa;
        b     = xb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        e.hi  = eh;
        e.lo  = el;
        e.dz  = ed;
        e.cyc = cyc + 33;
        e.id  = id;
        sb_q.push_back(e);
    endtask

    // Wait until all issued operations have been checked
    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            failed++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, {31'd0, busy}, 32'd0);
        chk("rst_done", 0, {31'd0, done}, 32'd0);
        chk("rst_dz",   0, {31'd0, dz},   32'd0);
        chk("rst_hi",   0, hi, 32'd0);
        chk("rst_lo",   0, lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU max x max, with busy-duration check
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 1, 32'(n), 32'd33);
        chk("done_when_idle", 1, {31'd0, done}, 32'd1);
        drain();

        issue(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 2); drain();
        issue(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 3); drain();
        issue(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 4); drain();
        issue(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 5); drain();
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 6); drain();
        issue(2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 7); drain();
        issue(2'b10, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1, 8); drain();
        issue(2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 9); drain();
        issue(2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 10); drain();
        issue(2'b00, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 11); drain();

        // start mid-CALC must be ignored
        issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 12);
        repeat (5) @(negedge clk);
        op = 2'b11; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start in the done cycle is accepted
        issue(2'b11, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 13);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            failed++;
            $display("FAIL done_timeout: got done=0 expected 1");
        end
        issue(2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 32'd6, 1'b0, 14);
        drain();

        // Asynchronous reset mid-CALC discards the operation
        issue(2'b11, 32'd50, 32'd3, 32'd2, 32'd16, 1'b0, 15);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 15, {31'd0, busy}, 32'd0);
        chk("mid_rst_done", 15, {31'd0, done}, 32'd0);
        chk("mid_rst_hi",   15, hi, 32'd0);
        chk("mid_rst_lo",   15, lo, 32'd0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(2'b11, 32'd50, 32'd3, 32'd2, 32'd16, 1'b0, 16);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
